sayeh_mem_responder: RTL and testbench
======================================

// Module: sayeh_mem_responder
// PURPOSE
//  Bus responder (memory slave) for the SAYEH CPU memory/IO bus. Decodes ReadMem/WriteMem
//  (and ReadIO/WriteIO when enabled), holds a word-addressed RAM, drives Databus on reads and
//  raises MemDataready after a configurable number of wait states. Sits on the system bus
//  opposite the CPU, whose controller stalls until MemDataready.
// PARAMETERS
//  ADDR_WIDTH   10  RAM depth is 2**ADDR_WIDTH 16-bit words; Addressbus[15:ADDR_WIDTH] ignored
//  WAIT_CYCLES  2   wait states between request acceptance and MemDataready (0..15)
// PORTS
//  clk           in    1   system clock; all state updates on rising edge
//  ExternalReset in    1   synchronous, active-high reset
//  ReadMem       in    1   CPU memory read request, level, held until MemDataready seen
//  WriteMem      in    1   CPU memory write request, level, held until MemDataready seen
//  ReadIO        in    1   CPU IO read request (used only with SAYEH_IO_PORTS_EN)
//  WriteIO       in    1   CPU IO write request (used only with SAYEH_IO_PORTS_EN)
//  Addressbus    in    16  word address, stable while request asserted
//  Databus       inout 16  driven by block only in RESP/HOLD of a read; else high-Z
//  MemDataready  out   1   one-cycle completion pulse
//  Busy          out   1   high in any state other than IDLE
//  ReqError      out   1   one-cycle pulse on illegal request combination
//  PortIn        in    16  external input word (IO address 1)
//  PortOut       out   16  external output register (IO address 0)
// BEHAVIOUR
//  - Reset (checked every edge, wins over all): state=IDLE, MemDataready=0, Busy=0,
//    ReqError=0, Databus high-Z, PortOut=0. RAM contents NOT cleared. Reset mid-transaction
//    aborts it; an aborted write never commits.
//  - FSM IDLE -> WAIT -> RESP -> HOLD -> IDLE.
//    IDLE: sample requests; exactly one asserted -> latch kind + Addressbus[ADDR_WIDTH-1:0]
//      (+Databus on write); go WAIT (or RESP directly if WAIT_CYCLES==0). Zero or >1
//      asserted -> stay IDLE; >1 asserted additionally pulses ReqError next cycle.
//    WAIT: down-counter loaded with WAIT_CYCLES-1; at 0 go RESP.
//    RESP: MemDataready=1 for this single cycle; write commits to RAM on the RESP edge;
//      read data (sync RAM, issued at acceptance) drives Databus. Go HOLD.
//    HOLD: MemDataready=0; read data stays on Databus while the original request is still
//      high; when it drops, release Databus same cycle and go IDLE. No new request accepted
//      until one IDLE cycle with the original request low (no double-issue).
//  - Latency: request sampled at edge T -> MemDataready high in cycle T+WAIT_CYCLES+1.
//  - Request dropped early (before RESP): complete anyway, write commits, ready pulses.
//  - Address aliasing: upper address bits ignored; 0x0400 with ADDR_WIDTH=10 hits word 0.
//  - Latched address/data used throughout; Addressbus changes after acceptance are ignored.
// CONFIGURATION
//  SAYEH_IO_PORTS_EN defined: ReadIO/WriteIO decoded as requests with the same FSM/latency;
//    IO addr[0]==0 -> PortOut (R/W), addr[0]==1 -> PortIn (read-only, writes dropped);
//    PortOut updates on the RESP edge. Undefined: ReadIO/WriteIO ignored (never counted,
//    never cause ReqError), PortOut tied 0, PortIn unused.
// STRUCTURE
//  - Shared include sayeh_bus_defs.vh: data width 16, FSM state encodings, request-kind
//    codes (MEM_RD, MEM_WR, IO_RD, IO_WR), IO address constants.
//  - Sub-module sayeh_mem_array: single-port synchronous RAM (addr, wdata, we, rdata),
//    one-cycle read latency; FSM, counter and tri-state control stay in this module.
// TESTING
//  - Reset: hold ExternalReset 3 cycles mid-read -> MemDataready=0, Busy=0, Databus Z next edge.
//  - Write 0xBEEF @0x0012, then read 0x0012 (WAIT_CYCLES=2) -> ready in cycle T+3, Databus=0xBEEF.
//  - WAIT_CYCLES=0: read -> MemDataready one cycle after sampling; single pulse only.
//  - ReadMem+WriteMem together -> ReqError pulse, no ready, RAM unchanged.
//  - Write 0x1234 @0x0405 (ADDR_WIDTH=10), read 0x0005 -> 0x1234 (aliasing).
//  - With SAYEH_IO_PORTS_EN: WriteIO 0x00A5 @0 -> PortOut=0x00A5; PortIn=0x5A5A,
//    ReadIO @1 -> Databus=0x5A5A; without macro: WriteIO -> no ready, PortOut=0.

Source files
------------

// File: rtl/sayeh_mem_responder_pkg.sv
// Shared types and constants for the SAYEH memory/IO bus responder.
package sayeh_mem_responder_pkg;

   localparam int DATA_W = 16;

   // IO address decode uses bit 0 only
   localparam logic IO_ADDR_PORTOUT = 1'b0;
   localparam logic IO_ADDR_PORTIN  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   // Encoding matches the bit position of the request line in the request vector
   typedef enum logic [1:0] {
      MEM_RD = 2'd0,
      MEM_WR = 2'd1,
      IO_RD  = 2'd2,
      IO_WR  = 2'd3
   } kind_t;

   typedef struct packed {
      state_t     state;
      logic       drive;
      logic [3:0] wait_cnt;
   } dbg_t;

   function automatic logic is_read(kind_t k);
      return (k == MEM_RD) || (k == IO_RD);
   endfunction

endpackage

// File: rtl/sayeh_bus_if.sv
// SAYEH system bus request/response signals (Databus is carried separately as an inout).
interface sayeh_bus_if;

   // Handshake: a request line (ReadMem/WriteMem/ReadIO/WriteIO) is the valid. The master
   // holds it and Addressbus stable until it sees the one-cycle MemDataready, then drops
   // it. The slave consumes the request at acceptance and holds read data until the drop.
   logic        ReadMem;
   logic        WriteMem;
   logic        ReadIO;
   logic        WriteIO;
   logic [15:0] Addressbus;
   logic        MemDataready;
   logic        Busy;
   logic        ReqError;
   logic [15:0] PortIn;
   logic [15:0] PortOut;

   modport master (
      output ReadMem, WriteMem, ReadIO, WriteIO, Addressbus, PortIn,
      input  MemDataready, Busy, ReqError, PortOut
   );

   modport slave (
      input  ReadMem, WriteMem, ReadIO, WriteIO, Addressbus, PortIn,
      output MemDataready, Busy, ReqError, PortOut
   );

endinterface

// File: rtl/sayeh_mem_array.sv
// Single-port synchronous RAM, one-cycle read latency, read-before-write.
module sayeh_mem_array #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_W     = 16
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  we,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/sayeh_mem_responder.sv
// SAYEH bus memory responder: RAM slave with wait states and tri-state Databus.
// Optional IO ports (PortOut/PortIn) are enabled by defining SAYEH_IO_PORTS_EN.
module sayeh_mem_responder
   import sayeh_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              ExternalReset,
   sayeh_bus_if.slave        bus,
   inout  wire  [DATA_W-1:0] Databus,
   output dbg_t              dbg
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t                  state;
   kind_t                   kind;
   kind_t                   req_kind;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_W-1:0]       wdata_q;
   logic [3:0]              wait_cnt;
   logic                    ready_q, busy_q, err_q;
   logic [3:0]              req_vec;
   logic                    req_one, req_multi, orig_req, drive_en, ram_we;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic [DATA_W-1:0]       ram_rdata, rd_word;
   logic                    unused_bits;

`ifdef SAYEH_IO_PORTS_EN
   logic [DATA_W-1:0] port_out_q;
   assign req_vec     = {bus.WriteIO, bus.ReadIO, bus.WriteMem, bus.ReadMem};
   assign rd_word     = (kind != IO_RD) ? ram_rdata :
                        (addr_q[0] == IO_ADDR_PORTIN) ? bus.PortIn : port_out_q;
   assign bus.PortOut = port_out_q;
   assign unused_bits = ^bus.Addressbus[15:ADDR_WIDTH];
`else
   assign req_vec     = {2'b00, bus.WriteMem, bus.ReadMem};
   assign rd_word     = ram_rdata;
   assign bus.PortOut = '0;
   assign unused_bits = ^{bus.Addressbus[15:ADDR_WIDTH], bus.PortIn};
`endif

   always_comb begin
      req_multi = |(req_vec & (req_vec - 4'd1));
      req_one   = (|req_vec) && !req_multi;
      req_kind  = MEM_RD;
      if (req_vec[1]) req_kind = MEM_WR;
      if (req_vec[2]) req_kind = IO_RD;
      if (req_vec[3]) req_kind = IO_WR;
   end

   // HOLD tracks only the request line that started this transaction
   always_comb begin
      orig_req = 1'b0;
      case (kind)
         MEM_RD:  orig_req = bus.ReadMem;
         MEM_WR:  orig_req = bus.WriteMem;
         IO_RD:   orig_req = bus.ReadIO;
         IO_WR:   orig_req = bus.WriteIO;
         default: orig_req = 1'b0;
      endcase
   end

   // RAM read is issued from the live bus at acceptance, then from the latched address
   assign ram_addr = (state == ST_IDLE) ? bus.Addressbus[ADDR_WIDTH-1:0] : addr_q;
   assign ram_we   = (state == ST_RESP) && (kind == MEM_WR) && !ExternalReset;
   assign drive_en = is_read(kind) &&
                     ((state == ST_RESP) || ((state == ST_HOLD) && orig_req));
   assign Databus  = drive_en ? rd_word : 'z;

   sayeh_mem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_W(DATA_W)) u_array (
      .clk   (clk),
      .addr  (ram_addr),
      .wdata (wdata_q),
      .we    (ram_we),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (ExternalReset) begin
         state    <= ST_IDLE;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         wait_cnt <= 4'd0;
`ifdef SAYEH_IO_PORTS_EN
         port_out_q <= '0;
`endif
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_one) begin
                  kind    <= req_kind;
                  addr_q  <= bus.Addressbus[ADDR_WIDTH-1:0];
                  wdata_q <= Databus;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state   <= ST_RESP;
                     ready_q <= 1'b1;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end
               end else begin
                  err_q <= req_multi;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state   <= ST_RESP;
                  ready_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               state <= ST_HOLD;
`ifdef SAYEH_IO_PORTS_EN
               if (kind == IO_WR && addr_q[0] == IO_ADDR_PORTOUT) begin
                  port_out_q <= wdata_q;
               end
`endif
            end
            ST_HOLD: begin
               if (!orig_req) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.MemDataready = ready_q;
   assign bus.Busy         = busy_q;
   assign bus.ReqError     = err_q;
   assign dbg              = {state, drive_en, wait_cnt};

endmodule

// File: tb/tb_sayeh_mem_responder.sv
// Self-checking bench for sayeh_mem_responder: WAIT_CYCLES=2 (dut_a) and WAIT_CYCLES=0 (dut_b).
module tb_sayeh_mem_responder;
   import sayeh_mem_responder_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sayeh_bus_if bus_a ();
   sayeh_bus_if bus_b ();
   wire  [15:0] data_a, data_b;
   logic [15:0] tb_wd;
   logic        tb_we_a, tb_we_b;
   dbg_t        dbg_a, dbg_b;

   assign data_a = tb_we_a ? tb_wd : 16'bz;
   assign data_b = tb_we_b ? tb_wd : 16'bz;

   sayeh_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut_a (
      .clk (clk), .ExternalReset (rst), .bus (bus_a), .Databus (data_a), .dbg (dbg_a)
   );
   sayeh_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
      .clk (clk), .ExternalReset (rst), .bus (bus_b), .Databus (data_b), .dbg (dbg_b)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] exp_q[$];
   logic [15:0] model_a [1024];
   logic [15:0] addrs [6];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic get_ready(input bit s);
      return s ? bus_b.MemDataready : bus_a.MemDataready;
   endfunction
   function automatic logic get_busy(input bit s);
      return s ? bus_b.Busy : bus_a.Busy;
   endfunction
   function automatic logic get_drive(input bit s);
      return s ? dbg_b.drive : dbg_a.drive;
   endfunction
   function automatic logic [15:0] get_data(input bit s);
      return s ? data_b : data_a;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input bit s, input kind_t k, input bit on, input logic [15:0] addr);
      logic [3:0] v;
      v = on ? (4'b0001 << k) : 4'b0000;
      if (s) begin
         bus_b.ReadMem = v[0]; bus_b.WriteMem = v[1]; bus_b.ReadIO = v[2]; bus_b.WriteIO = v[3];
         bus_b.Addressbus = addr;
      end else begin
         bus_a.ReadMem = v[0]; bus_a.WriteMem = v[1]; bus_a.ReadIO = v[2]; bus_a.WriteIO = v[3];
         bus_a.Addressbus = addr;
      end
   endtask

   task automatic set_we(input bit s, input logic on);
      if (s) tb_we_b = on;
      else   tb_we_a = on;
   endtask

   // One complete transaction; address and write data are scrambled after acceptance
   task automatic txn(input bit s, input kind_t k, input logic [15:0] addr,
                      input logic [15:0] wd, input logic [15:0] exp, input int lat);
      bit          rd, seen;
      int          cyc;
      logic [15:0] want;
      rd   = (k == MEM_RD) || (k == IO_RD);
      want = 16'h0;
      @(negedge clk);
      if (rd) exp_q.push_back(exp);
      tb_wd = wd;
      set_we(s, !rd);
      set_req(s, k, 1'b1, addr);
      seen = 1'b0;
      cyc  = -1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (get_ready(s)) begin
            seen = 1'b1;
            cyc  = i;
            break;
         end
         set_req(s, k, 1'b1, ~addr);
         tb_wd = ~wd;
      end
      check("ready_seen", 32'(seen), 32'd1);
      check("latency", cyc, lat);
      if (rd) begin
         check("rd_drive", 32'(get_drive(s)), 32'd1);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("rd_data", get_data(s), want);
         end else begin
            check("exp_q_size", exp_q.size(), 1);
         end
      end
      @(negedge clk);
      check("ready_pulse", 32'(get_ready(s)), 32'd0);
      check("hold_drive", 32'(get_drive(s)), 32'(rd));
      if (rd) check("hold_data", get_data(s), want);
      set_req(s, k, 1'b0, addr);
      set_we(s, 1'b0);
      #1;
      check("release", 32'(get_drive(s)), 32'd0);
      @(negedge clk);
      check("idle_busy", 32'(get_busy(s)), 32'd0);
   endtask

   task automatic wr_a(input logic [15:0] addr, input logic [15:0] data);
      txn(1'b0, MEM_WR, addr, data, 16'h0, 2);
      model_a[addr[9:0]] = data;
   endtask

   task automatic rd_a(input logic [15:0] addr);
      txn(1'b0, MEM_RD, addr, 16'h0, model_a[addr[9:0]], 2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      rst = 1'b1;
      tb_wd = 16'h0; tb_we_a = 1'b0; tb_we_b = 1'b0;
      set_req(1'b0, MEM_RD, 1'b0, 16'h0);
      set_req(1'b1, MEM_RD, 1'b0, 16'h0);
      bus_a.PortIn = 16'h0;
      bus_b.PortIn = 16'h0;
      repeat (3) @(negedge clk);
      check("rst_ready",   32'(bus_a.MemDataready), 32'd0);
      check("rst_busy",    32'(bus_a.Busy), 32'd0);
      check("rst_err",     32'(bus_a.ReqError), 32'd0);
      check("rst_drive",   32'(dbg_a.drive), 32'd0);
      check("rst_portout", bus_a.PortOut, 16'h0);
      rst = 1'b0;

      wr_a(16'h0012, 16'hBEEF);
      rd_a(16'h0012);

      // reset held 3 cycles in the middle of a read
      wr_a(16'h0020, 16'h1111);
      @(negedge clk);
      set_req(1'b0, MEM_RD, 1'b1, 16'h0020);
      @(negedge clk);
      check("mid_busy", 32'(bus_a.Busy), 32'd1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_ready", 32'(bus_a.MemDataready), 32'd0);
         check("rst_mid_busy",  32'(bus_a.Busy), 32'd0);
         check("rst_mid_drive", 32'(dbg_a.drive), 32'd0);
      end
      set_req(1'b0, MEM_RD, 1'b0, 16'h0);
      rst = 1'b0;

      // reset landing on the RESP edge of a write must not commit it
      @(negedge clk);
      tb_wd = 16'hDEAD; tb_we_a = 1'b1;
      set_req(1'b0, MEM_WR, 1'b1, 16'h0020);
      seen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (bus_a.MemDataready) begin
            seen = 1'b1;
            break;
         end
      end
      check("abort_ready_seen", 32'(seen), 32'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("abort_busy", 32'(bus_a.Busy), 32'd0);
      set_req(1'b0, MEM_WR, 1'b0, 16'h0);
      tb_we_a = 1'b0;
      rst = 1'b0;
      rd_a(16'h0020);

      // ReadMem + WriteMem together: error pulse only
      @(negedge clk);
      bus_a.ReadMem = 1'b1; bus_a.WriteMem = 1'b1; bus_a.Addressbus = 16'h0012;
      tb_wd = 16'h0000; tb_we_a = 1'b1;
      @(negedge clk);
      check("err_pulse", 32'(bus_a.ReqError), 32'd1);
      check("err_busy",  32'(bus_a.Busy), 32'd0);
      check("err_ready", 32'(bus_a.MemDataready), 32'd0);
      set_req(1'b0, MEM_RD, 1'b0, 16'h0);
      tb_we_a = 1'b0;
      @(negedge clk);
      check("err_single", 32'(bus_a.ReqError), 32'd0);
      check("err_ready2", 32'(bus_a.MemDataready), 32'd0);
      rd_a(16'h0012);

      // upper address bits alias onto the low word address
      wr_a(16'h0405, 16'h1234);
      rd_a(16'h0005);

      for (int i = 0; i < 6; i++) begin
         addrs[i] = 16'($urandom_range(0, 65535));
         wr_a(addrs[i], 16'($urandom_range(0, 65535)));
      end
      for (int i = 0; i < 6; i++) rd_a(addrs[i]);

      // zero wait states
      txn(1'b1, MEM_WR, 16'h0003, 16'h7777, 16'h0, 0);
      txn(1'b1, MEM_WR, 16'h03FF, 16'hA5A5, 16'h0, 0);
      txn(1'b1, MEM_RD, 16'h0003, 16'h0, 16'h7777, 0);
      txn(1'b1, MEM_RD, 16'h03FF, 16'h0, 16'hA5A5, 0);

`ifdef SAYEH_IO_PORTS_EN
      txn(1'b0, IO_WR, 16'h0000, 16'h00A5, 16'h0, 2);
      check("io_portout", bus_a.PortOut, 16'h00A5);
      bus_a.PortIn = 16'h5A5A;
      txn(1'b0, IO_RD, 16'h0001, 16'h0, 16'h5A5A, 2);
      txn(1'b0, IO_WR, 16'h0001, 16'hFFFF, 16'h0, 2);
      check("io_portin_ro", bus_a.PortOut, 16'h00A5);
      txn(1'b0, IO_RD, 16'h0000, 16'h0, 16'h00A5, 2);
`else
      @(negedge clk);
      tb_wd = 16'h00A5; tb_we_a = 1'b1;
      set_req(1'b0, IO_WR, 1'b1, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("io_off_ready", 32'(bus_a.MemDataready), 32'd0);
         check("io_off_busy",  32'(bus_a.Busy), 32'd0);
         check("io_off_err",   32'(bus_a.ReqError), 32'd0);
      end
      check("io_off_portout", bus_a.PortOut, 16'h0);
      set_req(1'b0, IO_WR, 1'b0, 16'h0);
      tb_we_a = 1'b0;
      rd_a(16'h0012);
`endif

      // ---------------- report ----------------
      check("q_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
